// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display path.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    // Bit positions inside a segment vector ordered {g,f,e,d,c,b,a}.
    typedef enum logic [2:0] {
        SEG_A = 3'd0,
        SEG_B = 3'd1,
        SEG_C = 3'd2,
        SEG_D = 3'd3,
        SEG_E = 3'd4,
        SEG_F = 3'd5,
        SEG_G = 3'd6
    } seg_bit_e;

    typedef logic [6:0] seg7_t;

    // Active-high hex glyphs 0-9, A, b, C, d, E, F.
    localparam seg7_t GLYPHS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit hex to active-high seven-segment glyph decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Table lookup of the glyph for one nibble.
    always_comb begin
        seg = GLYPHS[hex];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed hex display driver with per-frame shadow capture.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter bit          ACTIVE_LOW_SEG = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] out_msb,
    input  logic [7:0] out_lsb,
    input  logic       blank_lz,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int unsigned    CW      = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]  CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam seg7_t          SEG_OFF = {7{ACTIVE_LOW_SEG}};
    localparam logic           DP_OFF  = ACTIVE_LOW_SEG;

    logic [CW-1:0]           cnt;
    logic [1:0]              idx;
    logic [NUM_DIGITS*4-1:0] shadow;
    logic                    first;

    logic                    tick;
    logic                    frame_start;
    logic [3:0]              cur_nib;
    seg7_t                   glyph;
    logic                    blank3, blank2, blank1;
    logic                    digit_blank;
    logic [3:0]              an_next;
    logic                    dp_on;

    assign tick        = (cnt == CNT_MAX);
    assign frame_start = first || (tick && (idx == 2'd3));

    // Prescaler, digit index and shadow capture at each frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            idx    <= '0;
            shadow <= '0;
            first  <= 1'b1;
        end else begin
            // Prescaler holds during the capture cycle so digit 0 gets a full slot.
            if (!first) begin
                cnt <= tick ? '0 : cnt + 1'b1;
            end
            if (frame_start) begin
                shadow <= {out_msb, out_lsb};
                first  <= 1'b0;
                idx    <= '0;
            end else if (tick) begin
                idx <= idx + 2'd1;
            end
        end
    end

    assign cur_nib = shadow[{idx, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .hex (cur_nib),
        .seg (glyph)
    );

    // Leading-zero blanking chain and next-cycle digit drive.
    always_comb begin
        blank3 = blank_lz && (shadow[15:12] == 4'h0);
        blank2 = blank3 && (shadow[11:8] == 4'h0);
        blank1 = blank2 && (shadow[7:4] == 4'h0);
        case (idx)
            2'd3:    digit_blank = blank3;
            2'd2:    digit_blank = blank2;
            2'd1:    digit_blank = blank1;
            default: digit_blank = 1'b0;
        endcase
        an_next = digit_blank ? 4'b1111 : ~(4'b0001 << idx);
        dp_on   = (idx == 2'd2) && !blank2;
    end

    // Registered display outputs; dark until the first capture is visible.
    always_ff @(posedge clk) begin
        if (rst || first) begin
            an  <= 4'b1111;
            seg <= SEG_OFF;
            dp  <= DP_OFF;
        end else begin
            an  <= an_next;
            seg <= digit_blank ? SEG_OFF : (glyph ^ {7{ACTIVE_LOW_SEG}});
            dp  <= dp_on ^ ACTIVE_LOW_SEG;
        end
        frame_tick <= !rst && frame_start;
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4, active-low segments.
module tb_seg7_scan_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] out_msb = 8'h00;
    logic [7:0] out_lsb = 8'h00;
    logic       blank_lz = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    seg7_scan_driver #(
        .REFRESH_DIV    (4),
        .ACTIVE_LOW_SEG (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .out_msb    (out_msb),
        .out_lsb    (out_lsb),
        .blank_lz   (blank_lz),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks n cycles of digit d; blank digits expect an high, seg off, dp off.
    task automatic scan_digit(input int unsigned d, input logic [6:0] s,
                              input bit blank, input int unsigned n);
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        exp_an  = blank ? 4'b1111 : ~(4'b0001 << d);
        exp_seg = blank ? 7'h7F : s;
        exp_dp  = (d == 2 && !blank) ? 1'b0 : 1'b1;
        for (int unsigned k = 0; k < n; k++) begin
            step();
            check($sformatf("d%0d_c%0d_an", d, k), an, exp_an);
            check($sformatf("d%0d_c%0d_seg", d, k), seg, exp_seg);
            check($sformatf("d%0d_c%0d_dp", d, k), dp, exp_dp);
            check($sformatf("d%0d_c%0d_ft", d, k), frame_tick, (d == 3 && k == 3));
        end
    endtask

    task automatic check_dark(input string tag, input logic exp_ft);
        check({tag, "_an"}, an, 4'b1111);
        check({tag, "_seg"}, seg, 7'h7F);
        check({tag, "_dp"}, dp, 1'b1);
        check({tag, "_ft"}, frame_tick, exp_ft);
    endtask

    initial begin
        // Reset held for three cycles with non-zero inputs.
        rst = 1'b1; out_msb = 8'hAB; out_lsb = 8'hCD; blank_lz = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_dark($sformatf("rst%0d", i), 1'b0);
        end

        // Release: capture cycle, then frame_tick with display still dark.
        rst = 1'b0; out_msb = 8'h10; out_lsb = 8'h20;
        step();
        check_dark("cap", 1'b1);

        // Frame A: 0x1020 unblanked; frame_tick lands 16 cycles later.
        scan_digit(0, 7'h40, 1'b0, 4);
        scan_digit(1, 7'h24, 1'b0, 4);
        scan_digit(2, 7'h40, 1'b0, 4);
        scan_digit(3, 7'h79, 1'b0, 4);

        // Frame B: new inputs not yet captured, blanking has no effect on 0x1020.
        out_msb = 8'h00; out_lsb = 8'h20; blank_lz = 1'b1;
        scan_digit(0, 7'h40, 1'b0, 4);
        scan_digit(1, 7'h24, 1'b0, 4);
        scan_digit(2, 7'h40, 1'b0, 4);
        scan_digit(3, 7'h79, 1'b0, 4);

        // Frame C: 0x0020 with blanking, digits 3 and 2 dark.
        out_msb = 8'h00; out_lsb = 8'h00;
        scan_digit(0, 7'h40, 1'b0, 4);
        scan_digit(1, 7'h24, 1'b0, 4);
        scan_digit(2, 7'h7F, 1'b1, 4);
        scan_digit(3, 7'h7F, 1'b1, 4);

        // Frame D: 0x0000 with blanking, only digit 0 lit.
        out_msb = 8'h10; out_lsb = 8'h20;
        scan_digit(0, 7'h40, 1'b0, 4);
        scan_digit(1, 7'h7F, 1'b1, 4);
        scan_digit(2, 7'h7F, 1'b1, 4);
        scan_digit(3, 7'h7F, 1'b1, 4);

        // Frame E: 0x1020; inputs go to 0xFFFF while digit 1 is lit.
        blank_lz = 1'b0;
        scan_digit(0, 7'h40, 1'b0, 4);
        scan_digit(1, 7'h24, 1'b0, 1);
        out_msb = 8'hFF; out_lsb = 8'hFF;
        scan_digit(1, 7'h24, 1'b0, 3);
        scan_digit(2, 7'h40, 1'b0, 4);
        scan_digit(3, 7'h79, 1'b0, 4);

        // Frame F: 0xFFFF on all digits.
        scan_digit(0, 7'h0E, 1'b0, 4);
        scan_digit(1, 7'h0E, 1'b0, 4);
        scan_digit(2, 7'h0E, 1'b0, 4);
        scan_digit(3, 7'h0E, 1'b0, 4);

        // Frame G: reset pulse while digit 2 is lit.
        scan_digit(0, 7'h0E, 1'b0, 4);
        scan_digit(1, 7'h0E, 1'b0, 4);
        scan_digit(2, 7'h0E, 1'b0, 1);
        rst = 1'b1; out_msb = 8'hF2; out_lsb = 8'h01;
        step();
        check_dark("midrst", 1'b0);
        rst = 1'b0;
        step();
        check_dark("recap", 1'b1);
        scan_digit(0, 7'h79, 1'b0, 4);
        scan_digit(1, 7'h40, 1'b0, 4);
        scan_digit(2, 7'h24, 1'b0, 4);
        scan_digit(3, 7'h0E, 1'b0, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
